alu_seq: RTL and testbench

- Second-generation ALU for the simple CPU datapath.
- Parametrised operand width; operand latches with per-input load enables; tri-state result bus.
- Adds a start/busy/done handshake, multi-cycle iterative ops (multiply, variable shifts) and a registered status-flag set.
- Sits between the register file and the shared data bus; the control unit sequences it.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_iter_unit.sv | 57 +++++
 rtl/alu_seq.sv | 141 ++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and opcode helpers shared by the ALU files
package alu_pkg;

    localparam logic [3:0] OP_ADD         = 4'd0;
    localparam logic [3:0] OP_SUB         = 4'd1;
    localparam logic [3:0] OP_NOT         = 4'd2;
    localparam logic [3:0] OP_AND         = 4'd3;
    localparam logic [3:0] OP_OR          = 4'd4;
    localparam logic [3:0] OP_XOR         = 4'd5;
    localparam logic [3:0] OP_XNOR        = 4'd6;
    localparam logic [3:0] OP_PASS        = 4'd7;
    localparam logic [3:0] OP_MUL         = 4'd8;
    localparam logic [3:0] OP_SHL         = 4'd9;
    localparam logic [3:0] OP_SHR         = 4'd10;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return op == OP_MUL || op == OP_SHL || op == OP_SHR;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shift-add multiplier and bit-serial shifter, one step per cycle
// Ports: clk/rst_n clock and async active-low reset; load_i captures op_i/op1_i/op2_i;
//        step_i advances one iteration; res_o/carry_o show the value after the current
//        step, so the caller can latch them on the same edge as the final step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);

    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nx;
    logic [WIDTH-1:0]   mplier_q, sh_q, sh_nx;
    logic               mul_q, shl_q;

    always_comb begin
        acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
        sh_nx   = shl_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        res_o   = mul_q ? acc_nx[WIDTH-1:0] : sh_nx;
        // multiply carry means the product did not fit in WIDTH bits
        carry_o = mul_q ? |acc_nx[2*WIDTH-1:WIDTH] : (shl_q ? sh_q[WIDTH-1] : sh_q[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sh_q     <= '0;
            mul_q    <= 1'b0;
            shl_q    <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, op1_i};
            mplier_q <= op2_i;
            sh_q     <= op1_i;
            mul_q    <= op_i == OP_MUL;
            shl_q    <= op_i == OP_SHL;
        end else if (step_i) begin
            acc_q    <= acc_nx;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            sh_q     <= sh_nx;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with operand latches, start/busy/done handshake and registered flags
// Ports: clk/rst_n clock and async active-low reset; in1_i/in2_i with in1_en/in2_en load
//        the operand latches (in2 is the shift amount); op_i/start launch an operation;
//        busy/done handshake; out_en gates the tri-state out_bus; flag_z/n/c/v and err
//        are updated together with the result.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             in1_en,
    input  logic             in2_en,
    input  logic [OP_W-1:0]  op_i,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             out_en,
    output logic [WIDTH-1:0] out_bus,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int               CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t             state_q;
    logic [WIDTH-1:0]   op1_q, op2_q, result_q;
    logic [CNT_W-1:0]   cnt_q, cnt_ld;
    logic [WIDTH-1:0]   op1_eff, op2_eff, sc_r, it_res, fin_r;
    logic [WIDTH:0]     sum, diff;
    logic               sc_c, sc_v, sc_err, it_c, fin_c, fin_v, fin_e;
    logic               iter_go, launch, fin;

    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign out_bus = out_en ? result_q : {WIDTH{1'bz}};

    // latch-through: an operand loaded with start is already visible to this op
    assign op1_eff = (in1_en && !busy) ? in1_i : op1_q;
    assign op2_eff = (in2_en && !busy) ? in2_i : op2_q;

    // a zero-distance shift needs no iterations and completes like a single-cycle op
    assign iter_go = is_iter_op(op_i) && (op_i == OP_MUL || op2_eff != '0);
    assign launch  = state_q == IDLE && start;
    assign fin     = (launch && !iter_go) || (state_q == ITER && cnt_q == CNT_ONE);
    assign cnt_ld  = (op_i == OP_MUL || op2_eff >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH)
                                                                  : op2_eff[CNT_W-1:0];

    always_comb begin
        sum    = {1'b0, op1_eff} + {1'b0, op2_eff};
        diff   = {1'b0, op1_eff} - {1'b0, op2_eff};
        sc_r   = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = op_i >= OP_ILLEGAL_MIN;
        case (op_i)
            OP_ADD: begin
                sc_r = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
                sc_v = op1_eff[WIDTH-1] == op2_eff[WIDTH-1] && sc_r[WIDTH-1] != op1_eff[WIDTH-1];
            end
            OP_SUB: begin
                sc_r = diff[WIDTH-1:0];
                sc_c = diff[WIDTH];
                sc_v = op1_eff[WIDTH-1] != op2_eff[WIDTH-1] && sc_r[WIDTH-1] != op1_eff[WIDTH-1];
            end
            OP_NOT:         sc_r = ~op1_eff;
            OP_AND:         sc_r = op1_eff & op2_eff;
            OP_OR:          sc_r = op1_eff | op2_eff;
            OP_XOR:         sc_r = op1_eff ^ op2_eff;
            OP_XNOR:        sc_r = ~(op1_eff ^ op2_eff);
            OP_PASS:        sc_r = op1_eff;
            OP_SHL, OP_SHR: sc_r = op1_eff;
            default:        sc_r = '0;
        endcase
        fin_r = state_q == ITER ? it_res : sc_r;
        fin_c = state_q == ITER ? it_c : sc_c;
        fin_v = state_q == ITER ? 1'b0 : sc_v;
        fin_e = state_q == ITER ? 1'b0 : sc_err;
    end

    alu_iter_unit #(.WIDTH(WIDTH), .OP_W(OP_W)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (launch && iter_go),
        .step_i  (state_q == ITER),
        .op_i    (op_i),
        .op1_i   (op1_eff),
        .op2_i   (op2_eff),
        .res_o   (it_res),
        .carry_o (it_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    op1_q <= op1_eff;
                    op2_q <= op2_eff;
                    if (start) begin
                        state_q <= iter_go ? ITER : DONE;
                        cnt_q   <= cnt_ld;
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
            if (fin) begin
                result_q <= fin_r;
                flag_z   <= !fin_e && fin_r == '0;
                flag_n   <= fin_r[WIDTH-1];
                flag_c   <= fin_c;
                flag_v   <= fin_v;
                err      <= fin_e;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] in1_i = '0, in2_i = '0;
    logic         in1_en = 1'b0, in2_en = 1'b0;
    logic [3:0]   op_i = '0;
    logic         start = 1'b0, out_en = 1'b1;
    logic         busy, done, flag_z, flag_n, flag_c, flag_v, err;
    wire  [W-1:0] out_bus;
    wire  [4:0]   fl_obs = {err, flag_z, flag_n, flag_c, flag_v};

    int           tests = 0, fails = 0;
    logic [W-1:0] m1 = '0, m2 = '0;

    alu_seq #(.WIDTH(W), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in1_i(in1_i), .in2_i(in2_i), .in1_en(in1_en),
        .in2_en(in2_en), .op_i(op_i), .start(start), .busy(busy), .done(done),
        .out_en(out_en), .out_bus(out_bus), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, {err,z,n,c,v} and cycle of the done pulse from plain arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output int r, output int fl, output int lat);
        int m = 1 << W, h = 1 << (W - 1);
        int sa, sb, t, k;
        bit c = 0, v = 0, e = 0;
        sa  = a >= h ? a - m : a;
        sb  = b >= h ? b - m : b;
        r   = 0;
        lat = 1;
        k   = b < W ? b : W;
        case (op)
            0: begin t = a + b; r = t % m; c = t >= m; t = sa + sb; v = t < -h || t >= h; end
            1: begin r = (a - b + m) % m; c = a < b; t = sa - sb; v = t < -h || t >= h; end
            2: r = (m - 1) - a;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (m - 1) - (a ^ b);
            7: r = a;
            8: begin t = a * b; r = t % m; c = t >= m; lat = W + 1; end
            9: begin r = (a << k) % m; c = k > 0 && ((a >> (W - k)) & 1) == 1; lat = k + 1; end
            10: begin r = a >> k; c = k > 0 && ((a >> (k - 1)) & 1) == 1; lat = k + 1; end
            default: e = 1;
        endcase
        fl = {27'b0, e, r == 0 && !e, r[W-1], c, v};
    endfunction

    task automatic run(input int op, input bit l1, input int a, input bit l2, input int b,
                       input int exp_r, input string tag);
        int r, fl, lat, cyc, nb;
        if (l1) m1 = a[W-1:0];
        if (l2) m2 = b[W-1:0];
        model(op, int'(m1), int'(m2), r, fl, lat);
        @(negedge clk);
        in1_i = a[W-1:0]; in1_en = l1; in2_i = b[W-1:0]; in2_en = l2; op_i = op[3:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in1_en = 1'b0; in2_en = 1'b0;
        cyc = 1;
        nb = 0;
        while (!done && cyc < 40) begin
            if (!busy) nb++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_busy"}, nb, 0);
        chk({tag, "_res"}, out_bus, r[W-1:0]);
        chk({tag, "_flags"}, fl_obs, fl[4:0]);
        if (exp_r >= 0) chk({tag, "_const"}, out_bus, exp_r[W-1:0]);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done}, 0);
    endtask

    initial begin
        int cyc, nd, first;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", fl_obs, 0);
        chk("rst_bus", out_bus, 0);
        rst_n = 1'b1;

        run(0, 1, 'h15, 1, 'h2A, 'h3F, "add");
        out_en = 1'b0;
        #1 chk("hiz", out_bus !== 6'h3F, 1);
        out_en = 1'b1;
        run(1, 0, 0, 0, 0, 'h2B, "sub");
        run(2, 0, 0, 0, 0, 'h2A, "not");
        run(3, 0, 0, 0, 0, 'h00, "and");
        run(4, 0, 0, 0, 0, 'h3F, "or");
        run(5, 0, 0, 0, 0, 'h3F, "xor");
        run(6, 0, 0, 0, 0, 'h00, "xnor");
        run(1, 0, 0, 0, 0, 'h2B, "sub2");

        // reset in the middle of a multiply
        m1 = 7; m2 = 9;
        @(negedge clk);
        in1_i = 7; in2_i = 9; in1_en = 1'b1; in2_en = 1'b1; op_i = 8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in1_en = 1'b0; in2_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_flags", fl_obs, 0);
        chk("mid_rst_bus", out_bus, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m1 = 0; m2 = 0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_rst_nodone", nd, 0);
        run(7, 0, 0, 0, 0, 0, "pass_after_rst");

        run(8, 1, 7, 1, 9, 'h3F, "mul79");
        run(8, 1, 9, 0, 0, 'h11, "mul99");
        run(9, 1, 'h15, 1, 2, 'h14, "shl2");
        run(10, 0, 0, 1, 0, 'h15, "shr0");
        run(9, 0, 0, 1, 9, 'h00, "shl9");
        run(10, 0, 0, 1, 9, 'h00, "shr9");
        run(13, 0, 0, 0, 0, 'h00, "illegal");
        run(0, 1, 1, 1, 2, 'h03, "add_clr_err");

        // start and operand load pulsed while busy must be ignored
        m1 = 7; m2 = 9;
        @(negedge clk);
        in1_i = 7; in2_i = 9; in1_en = 1'b1; in2_en = 1'b1; op_i = 8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in1_en = 1'b0; in2_en = 1'b0;
        cyc = 1; nd = 0; first = 0;
        while (cyc < 14) begin
            if (done) begin
                nd++;
                if (first == 0) first = cyc;
            end
            in1_i  = 'h3F;
            op_i   = 0;
            in1_en = cyc == 2 || cyc == 3;
            start  = cyc == 2 || cyc == 3;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in1_en = 1'b0;
        chk("prot_first_done", first, 7);
        chk("prot_done_count", nd, 1);
        chk("prot_res", out_bus, 'h3F);
        run(7, 0, 0, 0, 0, 'h07, "prot_op1_kept");

        repeat (60) begin
            int op, a, b;
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, 63);
            b  = (op == 9 || op == 10) ? $urandom_range(0, 8) : $urandom_range(0, 63);
            run(op, $urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1, b, -1, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
